// File: rtl/bram_pkg.sv
// Shared constants and types for the 32x4 block RAM sequential writer.
// Pure declarations with no logic, so it adds no latency and has no backpressure.
package bram_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W:0]   cnt_t;

    typedef enum logic [2:0] {IDLE, WRITE, VERIFY, CHECK, FINISH} state_t;

    // Lengths above the RAM depth would write some addresses twice, so cap them.
    function automatic cnt_t clamp_len(input cnt_t l);
        return (l > cnt_t'(DEPTH)) ? cnt_t'(DEPTH) : l;
    endfunction

endpackage

// File: rtl/bram_addr_gen.sv
// Address pointer and down-counter for one sweep over the RAM, wrapping modulo DEPTH.
// The pointer and count update one cycle after load or step; last is decoded combinationally from the count.
// There is no handshake: the owner pulses step once for each address it consumes.
module bram_addr_gen
    import bram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] ptr,
    output logic              last
);

    cnt_t remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            remaining <= '0;
        end else if (load) begin
            ptr       <= base;
            remaining <= count;
        end else if (step) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    assign last = (remaining == cnt_t'(1));

endmodule

// File: rtl/bram_seq_writer.sv
// Writes a valid/ready stream of words to consecutive RAM addresses starting at a programmable base.
// There is one cycle from each accepted word to its registered RAM write; done follows the last write by one cycle.
// in_ready is high throughout WRITE, so the source sets the pace. Readback check: BRAM_SEQ_WRITER_VERIFY_EN.
module bram_seq_writer
    import bram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_w_data,
    input  logic [DATA_W-1:0] bram_r_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic              verify_err
);

    state_t state, state_nxt;
    logic   hs;
    logic   gen_load, gen_step, gen_last;
    addr_t  gen_base, gen_ptr;
    cnt_t   gen_count;

`ifdef BRAM_SEQ_WRITER_VERIFY_EN
    addr_t base_q;
    cnt_t  len_q;
    data_t wr_sum, rd_sum;
    logic  rd_v1, rd_v2, ve_q;
`endif

    assign in_ready = (state == WRITE);
    assign hs       = in_valid & in_ready;
    assign busy     = (state != IDLE);

    bram_addr_gen u_addr_gen (
        .clk   (clk),
        .rst   (rst),
        .load  (gen_load),
        .step  (gen_step),
        .base  (gen_base),
        .count (gen_count),
        .ptr   (gen_ptr),
        .last  (gen_last)
    );

    always_comb begin
        state_nxt = state;
        gen_load  = 1'b0;
        gen_step  = 1'b0;
        gen_base  = base_addr;
        gen_count = clamp_len(len);
        case (state)
            IDLE: begin
                if (start) begin
                    gen_load  = 1'b1;
                    state_nxt = (gen_count == '0) ? FINISH : WRITE;
                end
            end
            WRITE: begin
                if (in_valid) begin
                    if (gen_last) begin
`ifdef BRAM_SEQ_WRITER_VERIFY_EN
                        // Reload the same window for the readback sweep.
                        gen_load  = 1'b1;
                        gen_base  = base_q;
                        gen_count = len_q;
                        state_nxt = VERIFY;
`else
                        state_nxt = FINISH;
`endif
                    end else begin
                        gen_step = 1'b1;
                    end
                end
            end
`ifdef BRAM_SEQ_WRITER_VERIFY_EN
            VERIFY: begin
                gen_step = 1'b1;
                if (gen_last) state_nxt = CHECK;
            end
            CHECK: begin
                if (!rd_v1) state_nxt = FINISH;
            end
`endif
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_w_data <= '0;
            done        <= 1'b0;
            wr_count    <= '0;
        end else begin
            state   <= state_nxt;
            done    <= (state == FINISH);
            bram_we <= hs;
            if (hs) begin
                bram_addr   <= gen_ptr;
                bram_w_data <= in_data;
                wr_count    <= wr_count + 1'b1;
            end
            if (state == IDLE && start) wr_count <= '0;
`ifdef BRAM_SEQ_WRITER_VERIFY_EN
            if (state == VERIFY) bram_addr <= gen_ptr;
`endif
        end
    end

`ifdef BRAM_SEQ_WRITER_VERIFY_EN
    // A read issued in VERIFY returns two cycles later: one cycle for the address register, one for the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            len_q  <= '0;
            wr_sum <= '0;
            rd_sum <= '0;
            rd_v1  <= 1'b0;
            rd_v2  <= 1'b0;
            ve_q   <= 1'b0;
        end else begin
            rd_v1 <= (state == VERIFY);
            rd_v2 <= rd_v1;
            if (state == IDLE && start) begin
                base_q <= base_addr;
                len_q  <= clamp_len(len);
                wr_sum <= '0;
                rd_sum <= '0;
                ve_q   <= 1'b0;
            end
            if (hs)    wr_sum <= wr_sum ^ in_data;
            if (rd_v2) rd_sum <= rd_sum ^ bram_r_data;
            // The last read word is still on bram_r_data, so fold it into the compare directly.
            if (state == CHECK && !rd_v1) ve_q <= ((rd_sum ^ bram_r_data) != wr_sum);
        end
    end

    assign verify_err = ve_q;
`else
    logic unused_r_data;
    assign unused_r_data = ^bram_r_data;
    assign verify_err    = 1'b0;
`endif

endmodule
